onc_16_boot_loader: RTL and testbench



---
 rtl/onc_16_boot_loader.sv | 181 ++++++++++++++++++
 tb/tb_onc_16_boot_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onc_16_boot_loader.sv
// -----------------------------------------------------------------------------
// onc_16_boot_loader
//
// Purpose:
//   Loads a program image into the onc_16 instruction memory and releases the
//   core from reset once the image checks out. The image arrives as a byte
//   stream (valid/ready):
//     LEN_H, LEN_L            word count N, big-endian
//     N x (HI, LO)            instruction words, big-endian
//     SUM                     sum mod 256 of every preceding byte
//   Each word goes out on the memory write port as a one-cycle imem_we pulse,
//   on the cycle after its LO byte is accepted. On a good checksum the core
//   is released (cpu_n_rst=1, done=1). On an oversized length or a bad
//   checksum the loader parks in an error state (err=1, core held in reset,
//   input blocked). A reload pulse restarts loading from any state.
//
// Ports:
//   clock       system clock, rising edge
//   n_rst       asynchronous active-low reset
//   in_data     image byte
//   in_valid    in_data valid
//   in_ready    loader can accept a byte (decoded from state)
//   reload      one-cycle pulse: restart loading, abort any image in flight
//   imem_we     instruction memory write enable, one cycle per word
//   imem_waddr  word address of the write
//   imem_wdata  instruction word being written
//   cpu_n_rst   active-low reset to onc_16, high only while running
//   done        image loaded and verified
//   err         image rejected (length or checksum)
//
// INST_W must be 16 (two bytes per word); DEPTH must be <= 2**ADDR_W.
// -----------------------------------------------------------------------------
module onc_16_boot_loader #(
    parameter int INST_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clock,
    input  logic              n_rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [INST_W-1:0] imem_wdata,
    output logic              cpu_n_rst,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_LEN_H,
        S_LEN_L,
        S_HI,
        S_LO,
        S_SUM,
        S_RUN,
        S_ERR
    } state_t;

    // One extra bit so that a full image (N == DEPTH) counts up without wrap.
    localparam int CNT_W = ADDR_W + 1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] word_cnt;
    logic [7:0]       run_sum;
    logic [7:0]       hi_byte;
    logic [15:0]      len;        // word count N of the image being loaded
    logic [15:0]      len_in;     // N as it forms while LEN_L is on the bus
    logic             accept;
    logic             last_word;

    // A byte offered together with reload is dropped: reload wins.
    assign accept    = in_valid && in_ready && !reload;
    assign len_in    = {len[15:8], in_data};
    assign last_word = (32'(word_cnt) + 32'd1) == 32'(len);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update together from the values sampled at the same edge.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_LEN_H;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_nxt gets a default before the case so that every path
    // assigns it and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (reload) begin
            state_nxt = S_LEN_H;
        end else if (accept) begin
            case (state)
                S_LEN_H: state_nxt = S_LEN_L;
                S_LEN_L: begin
                    if (32'(len_in) > 32'(DEPTH)) begin
                        state_nxt = S_ERR;
                    end else if (len_in == 16'd0) begin
                        state_nxt = S_SUM;
                    end else begin
                        state_nxt = S_HI;
                    end
                end
                S_HI:    state_nxt = S_LO;
                S_LO:    state_nxt = last_word ? S_SUM : S_HI;
                S_SUM:   state_nxt = (in_data == run_sum) ? S_RUN : S_ERR;
                default: state_nxt = state;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_LEN_H, S_LEN_L, S_HI, S_LO, S_SUM: in_ready = 1'b1;
            default:                             in_ready = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and registered status
    // -------------------------------------------------------------------------
    // cpu_n_rst, done and err are registered from the next state rather than
    // decoded from the state bits, so the core's reset line cannot glitch
    // while the state register changes.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            word_cnt   <= '0;
            run_sum    <= '0;
            hi_byte    <= '0;
            len        <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            cpu_n_rst  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we   <= 1'b0;
            cpu_n_rst <= (state_nxt == S_RUN);
            done      <= (state_nxt == S_RUN);
            err       <= (state_nxt == S_ERR);

            if (reload) begin
                word_cnt <= '0;
                run_sum  <= '0;
            end else if (accept) begin
                // The checksum byte itself is the only byte left out of the sum.
                if (state != S_SUM) begin
                    run_sum <= run_sum + in_data;
                end
                case (state)
                    S_LEN_H: len[15:8] <= in_data;
                    S_LEN_L: len[7:0]  <= in_data;
                    S_HI:    hi_byte   <= in_data;
                    S_LO: begin
                        imem_we    <= 1'b1;
                        imem_waddr <= word_cnt[ADDR_W-1:0];
                        imem_wdata <= INST_W'({hi_byte, in_data});
                        word_cnt   <= word_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_onc_16_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_onc_16_boot_loader
//
// Self-checking bench for onc_16_boot_loader. Images are built in a byte
// queue; a reference model derives from the image alone which words must be
// written, how many bytes the loader will take, and whether it must end in
// done or err. A monitor collects every imem_we pulse for comparison.
// -----------------------------------------------------------------------------
module tb_onc_16_boot_loader;

    localparam int ADDR_W = 8;
    localparam int INST_W = 16;
    localparam int DEPTH  = 256;

    logic              clock = 1'b0;
    logic              n_rst;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [INST_W-1:0] imem_wdata;
    logic              cpu_n_rst;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  img[$];      // image bytes to send
    logic [23:0] wr_q[$];     // observed writes {addr, data}
    logic [23:0] exp_q[$];    // expected writes {addr, data}
    int          consumed;    // bytes the loader is expected to accept
    bit          exp_good;    // expected final outcome: 1 = done, 0 = err

    onc_16_boot_loader #(
        .INST_W(INST_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clock     (clock),
        .n_rst     (n_rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reload    (reload),
        .imem_we   (imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .cpu_n_rst (cpu_n_rst),
        .done      (done),
        .err       (err)
    );

    always #5 clock = ~clock;

    // Write monitor, sampling on the falling edge.
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            wr_q.push_back({imem_waddr, imem_wdata});
        end
    end

    // Global time bound.
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: what the image alone implies.
    task automatic model();
        int n;
        int s;
        exp_q.delete();
        n = int'(img[0]) * 256 + int'(img[1]);
        if (n > DEPTH) begin
            consumed = 2;
            exp_good = 1'b0;
        end else begin
            consumed = 2 + 2 * n + 1;
            s = 0;
            for (int i = 0; i < 2 + 2 * n; i++) s += int'(img[i]);
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({8'(i), img[2 + 2 * i], img[3 + 2 * i]});
            end
            exp_good = (int'(img[2 + 2 * n]) == (s % 256));
        end
    endtask

    // Random image of n words with a correct or deliberately wrong checksum.
    task automatic build_image(input int n, input bit good);
        int s;
        img.delete();
        img.push_back(8'(n / 256));
        img.push_back(8'(n % 256));
        for (int i = 0; i < 2 * n; i++) img.push_back(8'($urandom));
        s = 0;
        foreach (img[k]) s += int'(img[k]);
        if (good) img.push_back(8'(s));
        else      img.push_back(8'(s + int'($urandom_range(255, 1))));
    endtask

    // Sends the first `consumed` bytes, with up to gap_max idle cycles before
    // each. Called and returns on a falling edge.
    task automatic send_image(input int gap_max);
        for (int i = 0; i < consumed; i++) begin
            int gaps;
            gaps = int'($urandom_range(gap_max, 0));
            repeat (gaps) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clock);
            end
            check("in_ready_before_byte", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = img[i];
            @(negedge clock);
        end
        in_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic check_result(input string tag);
        check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(exp_q.size()));
        foreach (exp_q[k]) begin
            if (k < wr_q.size()) check({tag, "_write"}, 32'(wr_q[k]), 32'(exp_q[k]));
        end
        check({tag, "_done"},      32'(done),      32'(exp_good));
        check({tag, "_cpu_n_rst"}, 32'(cpu_n_rst), 32'(exp_good));
        check({tag, "_err"},       32'(err),       32'(!exp_good));
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        wr_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},   32'(in_ready),   32'd1);
        check({tag, "_imem_we"},    32'(imem_we),    32'd0);
        check({tag, "_imem_waddr"}, 32'(imem_waddr), 32'd0);
        check({tag, "_imem_wdata"}, 32'(imem_wdata), 32'd0);
        check({tag, "_cpu_n_rst"},  32'(cpu_n_rst),  32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clock);
        reload = 1'b0;
        check("reload_cpu_n_rst", 32'(cpu_n_rst), 32'd0);
        check("reload_done",      32'(done),      32'd0);
        check("reload_err",       32'(err),       32'd0);
        check("reload_in_ready",  32'(in_ready),  32'd1);
    endtask

    initial begin
        n_rst    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_vals("reset");
        n_rst = 1'b1;
        @(negedge clock);
        check_reset_vals("after_reset");

        // Normal load, valid every cycle.
        img = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
        model();
        send_image(0);
        check_result("normal");

        // Reload from S_RUN, then the same image with a bad checksum.
        do_reload();
        img = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
        model();
        send_image(0);
        check_result("bad_sum");

        // Input is ignored while in the error state.
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'($urandom);
            @(negedge clock);
        end
        in_valid = 1'b0;
        @(negedge clock);
        check("err_hold_nwrites", 32'(wr_q.size()), 32'd0);
        check("err_hold_err",     32'(err),         32'd1);
        check("err_hold_cpu",     32'(cpu_n_rst),   32'd0);

        // Length 257: rejected right after LEN_L, nothing written.
        do_reload();
        img = {8'h01, 8'h01};
        model();
        send_image(0);
        check_result("len_257");

        // Length 256 with random gaps: fills every address.
        do_reload();
        build_image(256, 1'b1);
        model();
        send_image(1);
        check_result("len_256");

        // Empty image.
        do_reload();
        img = {8'h00, 8'h00, 8'h00};
        model();
        send_image(0);
        check_result("empty");

        // Random images with valid gaps, good and bad checksums.
        for (int t = 0; t < 6; t++) begin
            do_reload();
            build_image(int'($urandom_range(12, 1)), (t % 2) == 0);
            model();
            send_image(3);
            check_result("random");
        end

        // Reload in the middle of a word, with a byte offered on that cycle.
        do_reload();
        img = {8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
        consumed = 5;
        send_image(0);
        reload   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h44;
        @(negedge clock);
        reload   = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        check("abort_nwrites", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) check("abort_write", 32'(wr_q[0]), 32'h00_1122);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_done",     32'(done),     32'd0);
        wr_q.delete();
        build_image(3, 1'b1);
        model();
        send_image(2);
        check_result("after_abort");

        // n_rst pulsed after the HI byte.
        do_reload();
        img = {8'h00, 8'h02, 8'h12};
        consumed = 3;
        send_image(0);
        n_rst = 1'b0;
        @(negedge clock);
        check_reset_vals("mid_reset");
        n_rst = 1'b1;
        @(negedge clock);
        wr_q.delete();
        build_image(4, 1'b1);
        model();
        send_image(0);
        check_result("after_mid_reset");

        // n_rst while a write pulse is in flight drops imem_we at once.
        n_rst = 1'b0;
        @(negedge clock);
        n_rst = 1'b1;
        @(negedge clock);
        img = {8'h00, 8'h01, 8'hAB};
        consumed = 3;
        send_image(0);
        in_valid = 1'b1;
        in_data  = 8'hCD;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check("inflight_we_high",  32'(imem_we),    32'd1);
        check("inflight_wdata",    32'(imem_wdata), 32'h0000_ABCD);
        n_rst = 1'b0;
        #1;
        check("inflight_we_drop",  32'(imem_we),    32'd0);
        check("inflight_wdata_rst", 32'(imem_wdata), 32'd0);
        @(negedge clock);
        n_rst = 1'b1;
        @(negedge clock);
        wr_q.delete();
        img = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
        model();
        send_image(2);
        check_result("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
